// File: rtl/sap_pkg.sv
// sap_pkg -- shared definitions for the SAP-style controller/sequencer.
//   * tstate_e    : T-state encoding (T1..T6, 0 = HALT), matches the tstate port
//   * OP_*        : opcode constants for IR[7:4]
//   * ctrl_t      : control word driven by the sequencer
//   * decode_ctrl : maps (state, IR, PC, active) to a control word
// Optional feature macro: CTRL_JMP_EN (adds JMP = 0011).
package sap_pkg;

    typedef enum logic [2:0] {
        T_HALT = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        T5     = 3'd5,
        T6     = 3'd6
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic [7:0] bus_out;
        logic       bus_drive;
        logic       reg_a_load_n;
        logic       reg_a_bus_enable_n;
        logic       reg_b_load_n;
        logic       out_load_n;
        logic       alu_enable;
        logic       alu_subtract;
        logic       ram_output_enable;
        logic       ram_load_mar_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        bus_out:            8'h00,
        bus_drive:          1'b0,
        reg_a_load_n:       1'b1,
        reg_a_bus_enable_n: 1'b1,
        reg_b_load_n:       1'b1,
        out_load_n:         1'b1,
        alu_enable:         1'b0,
        alu_subtract:       1'b0,
        ram_output_enable:  1'b0,
        ram_load_mar_reg:   1'b0
    };

    // act = 0 marks a paused cycle: the state is held and nothing is driven.
    function automatic ctrl_t decode_ctrl(input tstate_e st, input logic [7:0] ir,
                                          input logic [7:0] pc, input logic act);
        ctrl_t      c;
        logic [3:0] op;
        logic       alu_op;
        logic       mem_op;
        c      = CTRL_IDLE;
        op     = ir[7:4];
        alu_op = (op == OP_ADD) || (op == OP_SUB);
        mem_op = alu_op || (op == OP_LDA);
        if (act) begin
            case (st)
                T1: begin
                    c.bus_out          = pc;
                    c.bus_drive        = 1'b1;
                    c.ram_load_mar_reg = 1'b1;
                end
                T3: c.ram_output_enable = 1'b1;
                T4: begin
                    if (mem_op) begin
                        c.bus_out          = {4'h0, ir[3:0]};
                        c.bus_drive        = 1'b1;
                        c.ram_load_mar_reg = 1'b1;
                    end else if (op == OP_OUT) begin
                        c.reg_a_bus_enable_n = 1'b0;
                        c.out_load_n         = 1'b0;
                    end
`ifdef CTRL_JMP_EN
                    else if (op == OP_JMP) begin
                        c.bus_out   = {4'h0, ir[3:0]};
                        c.bus_drive = 1'b1;
                    end
`endif
                end
                T5: begin
                    if (op == OP_LDA) begin
                        c.ram_output_enable = 1'b1;
                        c.reg_a_load_n      = 1'b0;
                    end else if (alu_op) begin
                        c.ram_output_enable = 1'b1;
                        c.reg_b_load_n      = 1'b0;
                        c.alu_subtract      = (op == OP_SUB);
                    end
                end
                T6: begin
                    if (alu_op) begin
                        c.alu_enable   = 1'b1;
                        c.reg_a_load_n = 1'b0;
                        c.alu_subtract = (op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/program_counter.sv
// program_counter -- PC register with synchronous clear, increment (wraps
// modulo 2^PC_WIDTH) and, with CTRL_JMP_EN defined, parallel load.
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low clear
//   inc_i              : increment at the next edge
//   load_i, load_val_i : load value (CTRL_JMP_EN builds only; load wins over inc)
//   pc_next_o          : value the PC takes at the next edge
// Optional feature macro: CTRL_JMP_EN.
module program_counter #(
    parameter int PC_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
`ifdef CTRL_JMP_EN
    input  logic                load_i,
    input  logic [PC_WIDTH-1:0] load_val_i,
`endif
    output logic [PC_WIDTH-1:0] pc_next_o
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
`ifdef CTRL_JMP_EN
        if (load_i)
            pc_d = load_val_i;
        else
`endif
        if (inc_i)
            pc_d = pc_q + PC_WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) pc_q <= '0;
        else         pc_q <= pc_d;
    end

    // The sequencer registers its control word from next-state values,
    // so it needs the PC as it will be after this edge.
    assign pc_next_o = pc_d;

endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer -- SAP-style T1..T6 ring sequencer with instruction
// register and opcode decode. All outputs come straight from registers.
// Ports:
//   clk, reset_n (sync, active-low), run (1 = advance)
//   bus_in             : shared bus, sampled into IR at the end of T3
//   bus_out, bus_drive : value this block drives (PC in T1, operand in T4)
//   reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, out_load_n : active-low
//   alu_enable, alu_subtract, ram_output_enable, ram_load_mar_reg : active-high
//   halted, tstate     : status / debug
// Optional feature macro: CTRL_JMP_EN (JMP opcode 0011 loads PC in T4).
module controller_sequencer
    import sap_pkg::*;
#(
    parameter int PC_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_drive,
    output logic       reg_a_load_n,
    output logic       reg_a_bus_enable_n,
    output logic       reg_b_load_n,
    output logic       out_load_n,
    output logic       alu_enable,
    output logic       alu_subtract,
    output logic       ram_output_enable,
    output logic       ram_load_mar_reg,
    output logic       halted,
    output logic [2:0] tstate
);

    tstate_e             st_q, st_d;
    logic [7:0]          ir_q, ir_d;
    logic                act_q, act_d;      // current cycle is a live (non-paused) cycle
    logic                halted_q, halted_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic                pc_inc;
    logic [PC_WIDTH-1:0] pc_next;
`ifdef CTRL_JMP_EN
    logic                pc_load;
`endif

    program_counter #(.PC_WIDTH(PC_WIDTH)) u_pc (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .inc_i      (pc_inc),
`ifdef CTRL_JMP_EN
        .load_i     (pc_load),
        .load_val_i (PC_WIDTH'(ir_q[3:0])),
`endif
        .pc_next_o  (pc_next)
    );

    // run is captured into act_q, and a state only advances after one live
    // cycle in it. A state entered while run=0 is held with outputs idle,
    // and once run returns it still gets its full live cycle (e.g. RAM is
    // enabled for a whole cycle before IR samples the bus).
    always_comb begin
        st_d   = st_q;
        ir_d   = ir_q;
        act_d  = run;
        pc_inc = 1'b0;
`ifdef CTRL_JMP_EN
        pc_load = 1'b0;
`endif
        if (act_q) begin
            case (st_q)
                T1: st_d = T2;
                T2: begin
                    pc_inc = 1'b1;
                    st_d   = T3;
                end
                T3: begin
                    ir_d = bus_in;
                    st_d = (bus_in[7:4] == OP_HLT) ? T_HALT : T4;
                end
                T4: begin
`ifdef CTRL_JMP_EN
                    pc_load = (ir_q[7:4] == OP_JMP);
`endif
                    st_d = T5;
                end
                T5: st_d = T6;
                T6: st_d = T1;
                default: st_d = st_q;   // HALT is left only through reset
            endcase
        end
        halted_d = (st_d == T_HALT);
        ctrl_d   = decode_ctrl(st_d, ir_d, 8'(pc_next), act_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q     <= T1;
            ir_q     <= 8'h00;
            act_q    <= 1'b0;
            halted_q <= 1'b0;
            ctrl_q   <= CTRL_IDLE;
        end else begin
            st_q     <= st_d;
            ir_q     <= ir_d;
            act_q    <= act_d;
            halted_q <= halted_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign bus_out            = ctrl_q.bus_out;
    assign bus_drive          = ctrl_q.bus_drive;
    assign reg_a_load_n       = ctrl_q.reg_a_load_n;
    assign reg_a_bus_enable_n = ctrl_q.reg_a_bus_enable_n;
    assign reg_b_load_n       = ctrl_q.reg_b_load_n;
    assign out_load_n         = ctrl_q.out_load_n;
    assign alu_enable         = ctrl_q.alu_enable;
    assign alu_subtract       = ctrl_q.alu_subtract;
    assign ram_output_enable  = ctrl_q.ram_output_enable;
    assign ram_load_mar_reg   = ctrl_q.ram_load_mar_reg;
    assign halted             = halted_q;
    assign tstate             = st_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer -- directed scoreboard bench for controller_sequencer.
// Each stimulus row drives inputs at a falling edge and queues the outputs
// expected after the following rising edge; the monitor pops and compares
// 2 time units after every rising edge. JMP expectations follow CTRL_JMP_EN.
module tb_controller_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] bus_out;
    logic       bus_drive, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, out_load_n;
    logic       alu_enable, alu_subtract, ram_output_enable, ram_load_mar_reg;
    logic       halted;
    logic [2:0] tstate;

    controller_sequencer #(.PC_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .bus_in(bus_in),
        .bus_out(bus_out), .bus_drive(bus_drive),
        .reg_a_load_n(reg_a_load_n), .reg_a_bus_enable_n(reg_a_bus_enable_n),
        .reg_b_load_n(reg_b_load_n), .out_load_n(out_load_n),
        .alu_enable(alu_enable), .alu_subtract(alu_subtract),
        .ram_output_enable(ram_output_enable), .ram_load_mar_reg(ram_load_mar_reg),
        .halted(halted), .tstate(tstate)
    );

    always #5 clk = ~clk;

    // ctl = {bus_drive, ra_ld_n, ra_be_n, rb_ld_n, out_ld_n, alu_en, alu_sub, ram_oe, mar}
    localparam logic [8:0] C_IDLE = 9'b0_1111_0000;
    localparam logic [8:0] C_T1   = 9'b1_1111_0001;
    localparam logic [8:0] C_T3   = 9'b0_1111_0010;
    localparam logic [8:0] C_MEM4 = 9'b1_1111_0001;
    localparam logic [8:0] C_LDA5 = 9'b0_0111_0010;
    localparam logic [8:0] C_ADD5 = 9'b0_1101_0010;
    localparam logic [8:0] C_SUB5 = 9'b0_1101_0110;
    localparam logic [8:0] C_SUB6 = 9'b0_0111_1100;
    localparam logic [8:0] C_OUT4 = 9'b0_1010_0000;
`ifdef CTRL_JMP_EN
    localparam logic [8:0] C_JMP4 = 9'b1_1111_0000;
`endif

    typedef struct {
        logic [2:0] ts;
        logic       h;
        logic [7:0] bo;
        logic [8:0] ctl;
        string      nm;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [8:0] act_ctl;
    logic       excl_bad;
    int         n_vec = 0;
    int         n_mis = 0;

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            act_ctl = {bus_drive, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, out_load_n,
                       alu_enable, alu_subtract, ram_output_enable, ram_load_mar_reg};
            excl_bad = ($countones({bus_drive, ram_output_enable, alu_enable, ~reg_a_bus_enable_n}) > 1);
            n_vec++;
            if (tstate !== mon_e.ts || halted !== mon_e.h || bus_out !== mon_e.bo ||
                act_ctl !== mon_e.ctl || excl_bad) begin
                n_mis++;
                $display("FAIL %s: got ts=%0d halted=%b bus_out=%02h ctl=%09b, expected ts=%0d halted=%b bus_out=%02h ctl=%09b (bus contention=%b)",
                         mon_e.nm, tstate, halted, bus_out, act_ctl,
                         mon_e.ts, mon_e.h, mon_e.bo, mon_e.ctl, excl_bad);
            end
        end
    end

    task automatic cyc(input logic rn, input logic r, input logic [7:0] b,
                       input logic [2:0] ts, input logic h, input logic [7:0] bo,
                       input logic [8:0] ctl, input string nm);
        exp_t e;
        @(negedge clk);
        reset_n = rn;
        run     = r;
        bus_in  = b;
        e.ts = ts; e.h = h; e.bo = bo; e.ctl = ctl; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [7:0] pc);
        cyc(1'b1, 1'b1, 8'h00, 3'd1, 1'b0, pc,    C_T1,   "fetch T1");
        cyc(1'b1, 1'b1, 8'h00, 3'd2, 1'b0, 8'h00, C_IDLE, "fetch T2");
        cyc(1'b1, 1'b1, 8'h00, 3'd3, 1'b0, 8'h00, C_T3,   "fetch T3");
    endtask

    initial begin
        // reset state
        cyc(1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 8'h00, C_IDLE, "reset");
        cyc(1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 8'h00, C_IDLE, "reset");

        // LDA 9
        fetch(8'h00);
        cyc(1'b1, 1'b1, 8'h09, 3'd4, 1'b0, 8'h09, C_MEM4, "LDA T4");
        cyc(1'b1, 1'b1, 8'h00, 3'd5, 1'b0, 8'h00, C_LDA5, "LDA T5");
        cyc(1'b1, 1'b1, 8'h00, 3'd6, 1'b0, 8'h00, C_IDLE, "LDA T6");

        // SUB A
        fetch(8'h01);
        cyc(1'b1, 1'b1, 8'h2A, 3'd4, 1'b0, 8'h0A, C_MEM4, "SUB T4");
        cyc(1'b1, 1'b1, 8'h00, 3'd5, 1'b0, 8'h00, C_SUB5, "SUB T5");
        cyc(1'b1, 1'b1, 8'h00, 3'd6, 1'b0, 8'h00, C_SUB6, "SUB T6");

        // ADD C, reset for 2 clk mid-T5
        fetch(8'h02);
        cyc(1'b1, 1'b1, 8'h1C, 3'd4, 1'b0, 8'h0C, C_MEM4, "ADD T4");
        cyc(1'b1, 1'b1, 8'h00, 3'd5, 1'b0, 8'h00, C_ADD5, "ADD T5");
        cyc(1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 8'h00, C_IDLE, "reset mid-ADD");
        cyc(1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 8'h00, C_IDLE, "reset mid-ADD");

        // OUT from PC=0 (proves PC cleared)
        fetch(8'h00);
        cyc(1'b1, 1'b1, 8'hE0, 3'd4, 1'b0, 8'h00, C_OUT4, "OUT T4");
        cyc(1'b1, 1'b1, 8'h00, 3'd5, 1'b0, 8'h00, C_IDLE, "OUT T5");
        cyc(1'b1, 1'b1, 8'h00, 3'd6, 1'b0, 8'h00, C_IDLE, "OUT T6");

        // opcode 0011: JMP 7 when enabled, otherwise NOP
        fetch(8'h01);
`ifdef CTRL_JMP_EN
        cyc(1'b1, 1'b1, 8'h37, 3'd4, 1'b0, 8'h07, C_JMP4, "JMP T4");
`else
        cyc(1'b1, 1'b1, 8'h37, 3'd4, 1'b0, 8'h00, C_IDLE, "0011 NOP T4");
`endif
        cyc(1'b1, 1'b1, 8'h00, 3'd5, 1'b0, 8'h00, C_IDLE, "0011 T5");
        cyc(1'b1, 1'b1, 8'h00, 3'd6, 1'b0, 8'h00, C_IDLE, "0011 T6");
`ifdef CTRL_JMP_EN
        cyc(1'b1, 1'b1, 8'h00, 3'd1, 1'b0, 8'h07, C_T1,   "T1 after JMP");
`else
        cyc(1'b1, 1'b1, 8'h00, 3'd1, 1'b0, 8'h02, C_T1,   "T1 after 0011");
`endif
        cyc(1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 8'h00, C_IDLE, "reset");

        // 16 NOPs from PC=0, 17th fetch must wrap to 0
        for (int i = 0; i < 16; i++) begin
            fetch(8'(i));
            cyc(1'b1, 1'b1, {4'(4 + (i % 10)), 4'(i)}, 3'd4, 1'b0, 8'h00, C_IDLE, "NOP T4");
            cyc(1'b1, 1'b1, 8'h00, 3'd5, 1'b0, 8'h00, C_IDLE, "NOP T5");
            cyc(1'b1, 1'b1, 8'h00, 3'd6, 1'b0, 8'h00, C_IDLE, "NOP T6");
        end
        cyc(1'b1, 1'b1, 8'h00, 3'd1, 1'b0, 8'h00, C_T1,   "wrap T1");
        cyc(1'b1, 1'b1, 8'h00, 3'd2, 1'b0, 8'h00, C_IDLE, "wrap T2");

        // pause in T3 for 5 clk, then resume and halt
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b0, 8'h55, 3'd3, 1'b0, 8'h00, C_IDLE, "pause T3");
        cyc(1'b1, 1'b1, 8'h00, 3'd3, 1'b0, 8'h00, C_T3,   "resume T3");
        cyc(1'b1, 1'b1, 8'hF0, 3'd0, 1'b1, 8'h00, C_IDLE, "HLT");
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'(i % 3 != 0), 8'h09, 3'd0, 1'b1, 8'h00, C_IDLE, "halted");

        // reset releases HALT
        cyc(1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 8'h00, C_IDLE, "reset from HALT");
        cyc(1'b1, 1'b1, 8'h00, 3'd1, 1'b0, 8'h00, C_T1,   "T1 after HALT");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_mis++;
            $display("FAIL drain: %0d expected vectors never compared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
